// File: rtl/csr_rmw_ctrl_pkg.sv
// Shared constants for the CSR read/modify/write sequencer: op codes driven
// to the CSR unit, funct3 encodings, FSM state encoding and the read-only
// address field value.
package csr_rmw_ctrl_pkg;

    // Op codes seen by the CSR unit; 0 means no access.
    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_CSRRW  = 3'd1;
    localparam logic [2:0] OP_CSRRS  = 3'd2;
    localparam logic [2:0] OP_CSRRC  = 3'd3;
    localparam logic [2:0] OP_CSRRWI = 3'd4;
    localparam logic [2:0] OP_CSRRSI = 3'd5;
    localparam logic [2:0] OP_CSRRCI = 3'd6;

    // funct3 of the SYSTEM opcode; 000 and 100 are not CSR accesses.
    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_RSVD   = 3'b100;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // addr[11:10] value marking a read-only CSR.
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational helper for the CSR sequencer: funct3 -> op code mapping,
// register/immediate operand select and the new CSR value computation.
module csr_rmw_alu
    import csr_rmw_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_IDX      = 5,
    parameter int CSR_OP_WIDTH = 3
) (
    input  logic [2:0]              i_funct3,
    input  logic [REG_IDX-1:0]      i_rs1_idx,
    input  logic [XLEN-1:0]         i_rs1_val,
    input  logic [XLEN-1:0]         i_old_val,
    output logic [CSR_OP_WIDTH-1:0] o_op,
    output logic                    o_illegal,
    output logic                    o_write_form,
    output logic                    o_skip_write,
    output logic [XLEN-1:0]         o_new_val
);

    logic [2:0]      w_op;
    logic            w_imm;
    logic [XLEN-1:0] w_operand;

    // Decode funct3, pick the operand and compute the value to write back.
    always_comb begin
        w_op         = OP_NONE;
        w_imm        = 1'b0;
        o_illegal    = 1'b0;
        o_write_form = 1'b0;
        o_skip_write = 1'b0;
        o_new_val    = '0;
        case (i_funct3)
            F3_CSRRW:  w_op = OP_CSRRW;
            F3_CSRRS:  w_op = OP_CSRRS;
            F3_CSRRC:  w_op = OP_CSRRC;
            F3_CSRRWI: begin w_op = OP_CSRRWI; w_imm = 1'b1; end
            F3_CSRRSI: begin w_op = OP_CSRRSI; w_imm = 1'b1; end
            F3_CSRRCI: begin w_op = OP_CSRRCI; w_imm = 1'b1; end
            default:   o_illegal = 1'b1;
        endcase
        // zimm is the rs1 field, zero-extended.
        w_operand = w_imm ? {{(XLEN-REG_IDX){1'b0}}, i_rs1_idx} : i_rs1_val;
        case (w_op)
            OP_CSRRW, OP_CSRRWI: begin
                o_new_val    = w_operand;
                o_write_form = 1'b1;
            end
            OP_CSRRS, OP_CSRRSI: begin
                o_new_val    = i_old_val | w_operand;
                o_skip_write = (i_rs1_idx == '0);
            end
            OP_CSRRC, OP_CSRRCI: begin
                o_new_val    = i_old_val & ~w_operand;
                o_skip_write = (i_rs1_idx == '0);
            end
            default: o_new_val = '0;
        endcase
    end

    assign o_op = CSR_OP_WIDTH'(w_op);

endmodule

// File: rtl/csr_rmw_ctrl.sv
// CSR read/modify/write sequencer. Accepts one CSR instruction at a time,
// reads the CSR, writes the modified value and returns the old value to
// writeback. Handshake: a request is taken on a rising clk edge where
// req_valid_i and req_ready_o are both 1; req_ready_o stays 0 until the
// cycle after the done_o pulse.
// Optional macro CSR_RO_CHECK_EN: writes to addr[11:10]==2'b11 become illegal
// (read still performed, write dropped).
module csr_rmw_ctrl
    import csr_rmw_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CSR_ADDR     = 12,
    parameter int CSR_OP_WIDTH = 3,
    parameter int REG_IDX      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [2:0]              funct3_i,
    input  logic [CSR_ADDR-1:0]     csr_addr_i,
    input  logic [REG_IDX-1:0]      rs1_idx_i,
    input  logic [XLEN-1:0]         rs1_val_i,
    input  logic [REG_IDX-1:0]      rd_idx_i,
    output logic [CSR_ADDR-1:0]     csr_addr_o,
    output logic [CSR_OP_WIDTH-1:0] csr_op_o,
    output logic                    csr_rd_en_o,
    input  logic [XLEN-1:0]         csr_rdata_i,
    output logic                    csr_wr_en_o,
    output logic [XLEN-1:0]         csr_wdata_o,
    output logic                    done_o,
    output logic                    rd_we_o,
    output logic [REG_IDX-1:0]      rd_idx_o,
    output logic [XLEN-1:0]         rd_data_o,
    output logic                    illegal_o,
    output logic [2:0]              dbg_state_o
);

    state_t                  r_state;
    logic [2:0]              r_funct3;
    logic [CSR_ADDR-1:0]     r_addr;
    logic [REG_IDX-1:0]      r_rs1_idx;
    logic [XLEN-1:0]         r_rs1_val;
    logic [REG_IDX-1:0]      r_rd_idx;
    logic [XLEN-1:0]         r_old;

    logic                    r_req_ready;
    logic [CSR_ADDR-1:0]     r_addr_out;
    logic [CSR_OP_WIDTH-1:0] r_op_out;
    logic                    r_rd_en;
    logic                    r_wr_en;
    logic [XLEN-1:0]         r_wdata;
    logic                    r_done;
    logic                    r_rd_we;
    logic [REG_IDX-1:0]      r_rd_idx_out;
    logic [XLEN-1:0]         r_rd_data;
    logic                    r_illegal;

    logic                    w_idle;
    logic [2:0]              w_sel_funct3;
    logic [REG_IDX-1:0]      w_sel_rs1_idx;
    logic [XLEN-1:0]         w_sel_rs1_val;
    logic [XLEN-1:0]         w_sel_old;
    logic [CSR_OP_WIDTH-1:0] w_op;
    logic                    w_illegal_f3;
    logic                    w_write_form;
    logic                    w_skip_write;
    logic [XLEN-1:0]         w_new_val;
    logic                    w_ro_block;

    // In IDLE the ALU sees the incoming request (needed for the skip-read
    // path, which writes straight away); afterwards it sees the latched copy
    // and the CSR read data, which is valid during WAIT.
    assign w_idle        = (r_state == S_IDLE);
    assign w_sel_funct3  = w_idle ? funct3_i  : r_funct3;
    assign w_sel_rs1_idx = w_idle ? rs1_idx_i : r_rs1_idx;
    assign w_sel_rs1_val = w_idle ? rs1_val_i : r_rs1_val;
    assign w_sel_old     = w_idle ? '0        : csr_rdata_i;

    csr_rmw_alu #(
        .XLEN         (XLEN),
        .REG_IDX      (REG_IDX),
        .CSR_OP_WIDTH (CSR_OP_WIDTH)
    ) u_alu (
        .i_funct3     (w_sel_funct3),
        .i_rs1_idx    (w_sel_rs1_idx),
        .i_rs1_val    (w_sel_rs1_val),
        .i_old_val    (w_sel_old),
        .o_op         (w_op),
        .o_illegal    (w_illegal_f3),
        .o_write_form (w_write_form),
        .o_skip_write (w_skip_write),
        .o_new_val    (w_new_val)
    );

`ifdef CSR_RO_CHECK_EN
    logic [CSR_ADDR-1:0] w_sel_addr;
    assign w_sel_addr = w_idle ? csr_addr_i : r_addr;
    // A legal instruction that would actually write a read-only CSR.
    assign w_ro_block = (w_sel_addr[CSR_ADDR-1 -: 2] == CSR_RO_FIELD)
                        && !w_skip_write && !w_illegal_f3;
`else
    assign w_ro_block = 1'b0;
`endif

    // Sequencer FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_rs1_idx    <= '0;
            r_rs1_val    <= '0;
            r_rd_idx     <= '0;
            r_old        <= '0;
            r_req_ready  <= 1'b1;
            r_addr_out   <= '0;
            r_op_out     <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_rd_we      <= 1'b0;
            r_rd_idx_out <= '0;
            r_rd_data    <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_rd_we      <= 1'b0;
            r_rd_idx_out <= '0;
            r_rd_data    <= '0;
            r_illegal    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_funct3    <= funct3_i;
                        r_addr      <= csr_addr_i;
                        r_rs1_idx   <= rs1_idx_i;
                        r_rs1_val   <= rs1_val_i;
                        r_rd_idx    <= rd_idx_i;
                        r_old       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_illegal_f3) begin
                            r_state      <= S_RESP;
                            r_done       <= 1'b1;
                            r_illegal    <= 1'b1;
                            r_rd_idx_out <= rd_idx_i;
                        end else if (w_write_form && (rd_idx_i == '0) && !w_ro_block) begin
                            // Old value is discarded, so skip the read entirely.
                            r_state    <= S_WRITE;
                            r_wr_en    <= 1'b1;
                            r_wdata    <= w_new_val;
                            r_addr_out <= csr_addr_i;
                            r_op_out   <= w_op;
                        end else begin
                            r_state    <= S_READ;
                            r_rd_en    <= 1'b1;
                            r_addr_out <= csr_addr_i;
                            r_op_out   <= w_op;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_old <= csr_rdata_i;
                    if (w_skip_write || w_ro_block) begin
                        r_state      <= S_RESP;
                        r_done       <= 1'b1;
                        r_rd_we      <= (r_rd_idx != '0) && !w_ro_block;
                        r_illegal    <= w_ro_block;
                        r_rd_idx_out <= r_rd_idx;
                        r_rd_data    <= csr_rdata_i;
                        r_addr_out   <= '0;
                        r_op_out     <= '0;
                    end else begin
                        r_state <= S_WRITE;
                        r_wr_en <= 1'b1;
                        r_wdata <= w_new_val;
                    end
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_done       <= 1'b1;
                    r_rd_we      <= (r_rd_idx != '0);
                    r_rd_idx_out <= r_rd_idx;
                    r_rd_data    <= r_old;
                    r_addr_out   <= '0;
                    r_op_out     <= '0;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_addr_out  <= '0;
                    r_op_out    <= '0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign csr_addr_o  = r_addr_out;
    assign csr_op_o    = r_op_out;
    assign csr_rd_en_o = r_rd_en;
    assign csr_wr_en_o = r_wr_en;
    assign csr_wdata_o = r_wdata;
    assign done_o      = r_done;
    assign rd_we_o     = r_rd_we;
    assign rd_idx_o    = r_rd_idx_out;
    assign rd_data_o   = r_rd_data;
    assign illegal_o   = r_illegal;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Directed bench for csr_rmw_ctrl: one task per scenario, each issuing a CSR
// instruction, recording strobes/response per cycle and checking them inline.
module tb_csr_rmw_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [11:0] csr_addr_i;
    logic [4:0]  rs1_idx_i;
    logic [31:0] rs1_val_i;
    logic [4:0]  rd_idx_i;
    logic [11:0] csr_addr_o;
    logic [2:0]  csr_op_o;
    logic        csr_rd_en_o;
    logic [31:0] csr_rdata_i;
    logic        csr_wr_en_o;
    logic [31:0] csr_wdata_o;
    logic        done_o;
    logic        rd_we_o;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_data_o;
    logic        illegal_o;
    logic [2:0]  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Per-transaction record filled by capture()
    int          c_rd_cyc, c_wr_cyc, c_done_cyc, c_rd_cnt, c_wr_cnt, c_done_cnt;
    logic [11:0] c_rd_addr, c_wr_addr;
    logic [2:0]  c_rd_op, c_wr_op;
    logic [31:0] c_wdata, c_rd_data;
    logic [4:0]  c_rd_idx;
    logic        c_rd_we, c_illegal, c_ready_k1, c_ready_end;

    csr_rmw_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .funct3_i    (funct3_i),
        .csr_addr_i  (csr_addr_i),
        .rs1_idx_i   (rs1_idx_i),
        .rs1_val_i   (rs1_val_i),
        .rd_idx_i    (rd_idx_i),
        .csr_addr_o  (csr_addr_o),
        .csr_op_o    (csr_op_o),
        .csr_rd_en_o (csr_rd_en_o),
        .csr_rdata_i (csr_rdata_i),
        .csr_wr_en_o (csr_wr_en_o),
        .csr_wdata_o (csr_wdata_o),
        .done_o      (done_o),
        .rd_we_o     (rd_we_o),
        .rd_idx_o    (rd_idx_o),
        .rd_data_o   (rd_data_o),
        .illegal_o   (illegal_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request; the next rising edge is the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [4:0] rs1, input logic [31:0] rs1v,
                         input logic [4:0] rd);
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        csr_addr_i  = addr;
        rs1_idx_i   = rs1;
        rs1_val_i   = rs1v;
        rd_idx_i    = rd;
    endtask

    // Watch 8 cycles after the accept edge; cycle k is sampled 1ns after
    // edge k-1 counted from accept. CSR model returns csr_val only in the
    // cycle following a read strobe, junk otherwise.
    task automatic capture(input logic [31:0] csr_val);
        logic prev_rd;
        prev_rd = 1'b0;
        c_rd_cyc = -1; c_wr_cyc = -1; c_done_cyc = -1;
        c_rd_cnt = 0; c_wr_cnt = 0; c_done_cnt = 0;
        c_rd_addr = '0; c_wr_addr = '0; c_rd_op = '0; c_wr_op = '0;
        c_wdata = '0; c_rd_data = '0; c_rd_idx = '0; c_rd_we = 1'b0; c_illegal = 1'b0;
        c_ready_k1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            csr_rdata_i = prev_rd ? csr_val : 32'hDEAD_BEEF;
            prev_rd = csr_rd_en_o;
            if (k == 1) c_ready_k1 = req_ready_o;
            if (csr_rd_en_o) begin
                c_rd_cnt++;
                if (c_rd_cyc < 0) begin c_rd_cyc = k; c_rd_addr = csr_addr_o; c_rd_op = csr_op_o; end
            end
            if (csr_wr_en_o) begin
                c_wr_cnt++;
                if (c_wr_cyc < 0) begin c_wr_cyc = k; c_wr_addr = csr_addr_o; c_wr_op = csr_op_o; c_wdata = csr_wdata_o; end
            end
            if (done_o) begin
                c_done_cnt++;
                if (c_done_cyc < 0) begin
                    c_done_cyc = k; c_rd_we = rd_we_o; c_rd_data = rd_data_o;
                    c_rd_idx = rd_idx_o; c_illegal = illegal_o;
                end
            end
        end
        c_ready_end = req_ready_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid_i = 1'b0; funct3_i = '0; csr_addr_i = '0;
        rs1_idx_i = '0; rs1_val_i = '0; rd_idx_i = '0; csr_rdata_i = 32'hDEAD_BEEF;
        #12;
        n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
        n_checks++; if ({csr_rd_en_o, csr_wr_en_o, done_o, rd_we_o, illegal_o} !== 5'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 00000", {csr_rd_en_o, csr_wr_en_o, done_o, rd_we_o, illegal_o}); end
        n_checks++; if ({csr_addr_o, csr_op_o, csr_wdata_o, rd_idx_o, rd_data_o} !== '0) begin n_errors++; $display("FAIL reset_buses: addr %h op %h wdata %h rd %h data %h expected all 0", csr_addr_o, csr_op_o, csr_wdata_o, rd_idx_o, rd_data_o); end
        n_checks++; if (dbg_state_o !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // CSRRS x5, 0x340, x6=0xF0, CSR=0xF -> full sequence
    task automatic test_csrrs();
        issue(3'b010, 12'h340, 5'd6, 32'h0000_00F0, 5'd5);
        capture(32'h0000_000F);
        n_checks++; if (c_ready_k1 !== 1'b0) begin n_errors++; $display("FAIL rs_busy_ready: got %b expected 0", c_ready_k1); end
        n_checks++; if (c_rd_cyc !== 1 || c_rd_cnt !== 1) begin n_errors++; $display("FAIL rs_rd_en: cycle %0d count %0d expected cycle 1 count 1", c_rd_cyc, c_rd_cnt); end
        n_checks++; if (c_rd_addr !== 12'h340 || c_rd_op !== 3'd2) begin n_errors++; $display("FAIL rs_rd_addr_op: got %h/%0d expected 340/2", c_rd_addr, c_rd_op); end
        n_checks++; if (c_wr_cyc !== 3 || c_wr_cnt !== 1) begin n_errors++; $display("FAIL rs_wr_en: cycle %0d count %0d expected cycle 3 count 1", c_wr_cyc, c_wr_cnt); end
        n_checks++; if (c_wdata !== 32'h0000_00FF) begin n_errors++; $display("FAIL rs_wdata: got %h expected 000000ff", c_wdata); end
        n_checks++; if (c_wr_addr !== 12'h340 || c_wr_op !== 3'd2) begin n_errors++; $display("FAIL rs_wr_addr_op: got %h/%0d expected 340/2", c_wr_addr, c_wr_op); end
        n_checks++; if (c_done_cyc !== 4 || c_done_cnt !== 1) begin n_errors++; $display("FAIL rs_done: cycle %0d count %0d expected cycle 4 count 1", c_done_cyc, c_done_cnt); end
        n_checks++; if (c_rd_we !== 1'b1 || c_rd_data !== 32'h0000_000F || c_rd_idx !== 5'd5 || c_illegal !== 1'b0) begin n_errors++; $display("FAIL rs_resp: we %b data %h idx %0d ill %b expected 1 0000000f 5 0", c_rd_we, c_rd_data, c_rd_idx, c_illegal); end
        n_checks++; if (c_ready_end !== 1'b1) begin n_errors++; $display("FAIL rs_ready_after: got %b expected 1", c_ready_end); end
    endtask

    // CSRRCI x1, 0x300, zimm=3, CSR=0xFFFFFFFF; rs1_val is junk and must be ignored
    task automatic test_csrrci();
        issue(3'b111, 12'h300, 5'd3, 32'h1234_5678, 5'd1);
        capture(32'hFFFF_FFFF);
        n_checks++; if (c_wdata !== 32'hFFFF_FFFC || c_wr_op !== 3'd6) begin n_errors++; $display("FAIL rci_wdata: got %h op %0d expected fffffffc op 6", c_wdata, c_wr_op); end
        n_checks++; if (c_rd_data !== 32'hFFFF_FFFF || c_done_cyc !== 4 || c_rd_we !== 1'b1) begin n_errors++; $display("FAIL rci_resp: data %h cyc %0d we %b expected ffffffff 4 1", c_rd_data, c_done_cyc, c_rd_we); end
    endtask

    // CSRRSI x3, zimm=0x1F on 0x100; CSRRC x4 with 0xFF00 on 0xFFFF
    task automatic test_set_clear();
        issue(3'b110, 12'h341, 5'h1F, 32'hFFFF_0000, 5'd3);
        capture(32'h0000_0100);
        n_checks++; if (c_wdata !== 32'h0000_011F || c_wr_op !== 3'd5) begin n_errors++; $display("FAIL rsi_wdata: got %h op %0d expected 0000011f op 5", c_wdata, c_wr_op); end
        issue(3'b011, 12'h342, 5'd9, 32'h0000_FF00, 5'd4);
        capture(32'h0000_FFFF);
        n_checks++; if (c_wdata !== 32'h0000_00FF || c_wr_op !== 3'd3 || c_rd_data !== 32'h0000_FFFF) begin n_errors++; $display("FAIL rc_result: wdata %h op %0d data %h expected 000000ff 3 0000ffff", c_wdata, c_wr_op, c_rd_data); end
    endtask

    // CSRRW x0, 0x305, val 0x80000000 -> skip read
    task automatic test_skip_read();
        issue(3'b001, 12'h305, 5'd9, 32'h8000_0000, 5'd0);
        capture(32'h5555_5555);
        n_checks++; if (c_rd_cnt !== 0) begin n_errors++; $display("FAIL skr_no_read: got %0d reads expected 0", c_rd_cnt); end
        n_checks++; if (c_wr_cyc !== 1 || c_wdata !== 32'h8000_0000 || c_wr_op !== 3'd1 || c_wr_addr !== 12'h305) begin n_errors++; $display("FAIL skr_write: cyc %0d wdata %h op %0d addr %h expected 1 80000000 1 305", c_wr_cyc, c_wdata, c_wr_op, c_wr_addr); end
        n_checks++; if (c_done_cyc !== 2 || c_rd_we !== 1'b0 || c_rd_data !== 32'h0) begin n_errors++; $display("FAIL skr_resp: cyc %0d we %b data %h expected 2 0 0", c_done_cyc, c_rd_we, c_rd_data); end
    endtask

    // CSRRS x7, 0xC00, rs1=x0 -> skip write, legal in both builds
    task automatic test_skip_write();
        issue(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd7);
        capture(32'h0000_1234);
        n_checks++; if (c_wr_cnt !== 0 || c_rd_cyc !== 1) begin n_errors++; $display("FAIL skw_strobes: writes %0d read cyc %0d expected 0 1", c_wr_cnt, c_rd_cyc); end
        n_checks++; if (c_done_cyc !== 3 || c_rd_data !== 32'h0000_1234 || c_illegal !== 1'b0 || c_rd_we !== 1'b1 || c_rd_idx !== 5'd7) begin n_errors++; $display("FAIL skw_resp: cyc %0d data %h ill %b we %b idx %0d expected 3 00001234 0 1 7", c_done_cyc, c_rd_data, c_illegal, c_rd_we, c_rd_idx); end
    endtask

    // CSRRW x7, 0xC80: write to read-only CSR
    task automatic test_ro_write();
        issue(3'b001, 12'hC80, 5'd2, 32'h0000_0055, 5'd7);
        capture(32'h0000_ABCD);
`ifdef CSR_RO_CHECK_EN
        n_checks++; if (c_rd_cyc !== 1 || c_wr_cnt !== 0) begin n_errors++; $display("FAIL ro_strobes: read cyc %0d writes %0d expected 1 0", c_rd_cyc, c_wr_cnt); end
        n_checks++; if (c_done_cyc !== 3 || c_illegal !== 1'b1 || c_rd_we !== 1'b0) begin n_errors++; $display("FAIL ro_resp: cyc %0d ill %b we %b expected 3 1 0", c_done_cyc, c_illegal, c_rd_we); end
`else
        n_checks++; if (c_wr_cyc !== 3 || c_wdata !== 32'h0000_0055) begin n_errors++; $display("FAIL ro_write: cyc %0d wdata %h expected 3 00000055", c_wr_cyc, c_wdata); end
        n_checks++; if (c_done_cyc !== 4 || c_illegal !== 1'b0 || c_rd_we !== 1'b1 || c_rd_data !== 32'h0000_ABCD) begin n_errors++; $display("FAIL ro_resp: cyc %0d ill %b we %b data %h expected 4 0 1 0000abcd", c_done_cyc, c_illegal, c_rd_we, c_rd_data); end
`endif
    endtask

    // funct3 100 and 000 are illegal: response after one cycle, no CSR access
    task automatic test_illegal();
        issue(3'b100, 12'h340, 5'd6, 32'h0000_00F0, 5'd5);
        capture(32'h0000_000F);
        n_checks++; if (c_rd_cnt !== 0 || c_wr_cnt !== 0) begin n_errors++; $display("FAIL ill100_strobes: reads %0d writes %0d expected 0 0", c_rd_cnt, c_wr_cnt); end
        n_checks++; if (c_done_cyc !== 1 || c_illegal !== 1'b1 || c_rd_we !== 1'b0) begin n_errors++; $display("FAIL ill100_resp: cyc %0d ill %b we %b expected 1 1 0", c_done_cyc, c_illegal, c_rd_we); end
        issue(3'b000, 12'h001, 5'd1, 32'h0, 5'd2);
        capture(32'h0);
        n_checks++; if (c_rd_cnt !== 0 || c_wr_cnt !== 0 || c_done_cyc !== 1 || c_illegal !== 1'b1) begin n_errors++; $display("FAIL ill000: reads %0d writes %0d cyc %0d ill %b expected 0 0 1 1", c_rd_cnt, c_wr_cnt, c_done_cyc, c_illegal); end
    endtask

    // Reset while in WRITE, then a normal transaction
    task automatic test_reset_mid();
        bit seen_wr;
        seen_wr = 1'b0;
        issue(3'b010, 12'h340, 5'd6, 32'h0000_00F0, 5'd5);
        for (int k = 1; k <= 6 && !seen_wr; k++) begin
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            csr_rdata_i = 32'h0000_000F;
            if (csr_wr_en_o) seen_wr = 1'b1;
        end
        n_checks++; if (seen_wr !== 1'b1) begin n_errors++; $display("FAIL rstmid_reach_write: got %b expected 1", seen_wr); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({csr_rd_en_o, csr_wr_en_o, done_o, illegal_o} !== 4'b0 || csr_op_o !== 3'd0) begin n_errors++; $display("FAIL rstmid_strobes: got %b op %0d expected 0000 op 0", {csr_rd_en_o, csr_wr_en_o, done_o, illegal_o}, csr_op_o); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready_o !== 1'b1 || dbg_state_o !== 3'd0 || csr_wr_en_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle: ready %b state %0d wr %b expected 1 0 0", req_ready_o, dbg_state_o, csr_wr_en_o); end
        issue(3'b101, 12'h344, 5'd9, 32'hFFFF_FFFF, 5'd8);
        capture(32'h0000_0007);
        n_checks++; if (c_wdata !== 32'h0000_0009 || c_wr_cyc !== 3 || c_done_cyc !== 4 || c_rd_data !== 32'h0000_0007 || c_rd_we !== 1'b1) begin n_errors++; $display("FAIL rstmid_next: wdata %h wcyc %0d dcyc %0d data %h we %b expected 00000009 3 4 00000007 1", c_wdata, c_wr_cyc, c_done_cyc, c_rd_data, c_rd_we); end
    endtask

    initial begin
        test_reset();
        test_csrrs();
        test_csrrci();
        test_set_clear();
        test_skip_read();
        test_skip_write();
        test_ro_write();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Upstream sequencer for the CSR unit. Accepts one decoded SYSTEM/CSR instruction at a time from the execute stage.
- Translates funct3 into the core's CSR op code and performs the read / modify / write sequence against the CSR unit.
- Returns the old CSR value to the writeback path.
- Flags illegal CSR instructions to the trap logic.

Parameters:
- XLEN, 32, data width of rs1, CSR data and rd.
- CSR_ADDR, 12, CSR address width.
- CSR_OP_WIDTH, 3, width of the op code driven to the CSR unit.
- REG_IDX, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- req_valid_i  in  1  CSR instruction valid
- req_ready_o  out  1  block can accept a request
- funct3_i  in  3  instruction funct3
- csr_addr_i  in  CSR_ADDR  instruction CSR address
- rs1_idx_i  in  REG_IDX  rs1 index; doubles as zimm for immediate forms
- rs1_val_i  in  XLEN  rs1 register value
- rd_idx_i  in  REG_IDX  destination register index
- csr_addr_o  out  CSR_ADDR  address to the CSR unit
- csr_op_o  out  CSR_OP_WIDTH  op code to the CSR unit
- csr_rd_en_o  out  1  CSR read strobe
- csr_rdata_i  in  XLEN  CSR read data, valid the cycle after csr_rd_en_o
- csr_wr_en_o  out  1  CSR write strobe
- csr_wdata_o  out  XLEN  new CSR value
- done_o  out  1  one-cycle completion pulse
- rd_we_o  out  1  writeback enable, qualified by done_o
- rd_idx_o  out  REG_IDX  writeback index
- rd_data_o  out  XLEN  old CSR value
- illegal_o  out  1  illegal-instruction pulse, coincident with done_o

Behaviour:
- Reset: state=IDLE; every output 0, except req_ready_o=1.
- Op map from funct3: 001→1 (CSRRW), 010→2 (RS), 011→3 (RC), 101→4 (RWI), 110→5 (RSI), 111→6 (RCI).
- funct3 000 and 100 are illegal. Op code 0 means no access.
- Operand: rs1_val_i for register forms; zero-extended rs1_idx_i (zimm) for immediate forms.
- Accept: in IDLE, req_ready_o=1. On a clock edge with req_valid_i=1, latch all request fields and leave IDLE.
- Request inputs are ignored outside IDLE.
- State machine: IDLE → READ → WAIT → WRITE → RESP → IDLE.
  - READ: csr_rd_en_o=1.
  - WAIT: capture csr_rdata_i into old_q.
  - WRITE: csr_wr_en_o=1 and csr_wdata_o=new value.
  - RESP: done_o=1.
- csr_addr_o and csr_op_o hold the latched values from READ through WRITE. Both are 0 in IDLE and RESP.
- New value:
  - RW/RWI: operand.
  - RS/RSI: old_q | operand.
  - RC/RCI: old_q & ~operand.
- Skip read: RW/RWI with rd_idx=0 goes IDLE → WRITE directly, with no read side effects. old_q=0.
- Skip write: RS/RC/RSI/RCI with rs1_idx=0 go WAIT → RESP. No csr_wr_en_o pulse.
- Latency, counted from the accept edge:
  - Full sequence: done_o at +4 cycles.
  - Skip-read: done_o at +2 cycles.
  - Skip-write: done_o at +3 cycles.
- RESP outputs:
  - rd_we_o = (rd_idx≠0) && !illegal.
  - rd_data_o = old_q.
  - rd_idx_o = latched rd.
- Illegal funct3 goes IDLE → RESP with no CSR access: illegal_o=1, rd_we_o=0.
- Write to a read-only CSR (addr[11:10]==2'b11): see Optional Feature.
- No back-to-back accept: req_ready_o returns to 1 the cycle after RESP.
- Reset mid-operation: returns to IDLE immediately. No strobe is asserted after reset. Latched fields are cleared.

Optional Feature:
- Macro: CSR_RO_CHECK_EN.
- Defined: an instruction that would write a CSR with addr[11:10]==2'b11 (e.g. 0xC00 cycle, 0xC80 cycleh) is illegal.
  - The read still occurs.
  - WRITE is skipped.
  - RESP gives illegal_o=1, rd_we_o=0.
- Not defined:
  - The write strobe is issued anyway; the CSR unit ignores it.
  - illegal_o only flags illegal funct3.

Decomposition:
- Shared defines header holds:
  - op codes CSRRW..CSRRCI (1..6);
  - funct3 constants;
  - state encodings (IDLE, READ, WAIT, WRITE, RESP);
  - the read-only address-field constant 2'b11.
- Sub-module csr_rmw_alu: combinational funct3→op mapping, operand select and new-value computation.
- FSM, latches and handshake stay in the top module.

Test Plan:
- CSRRS x5, 0x340, rs1=x6 (0x0000_00F0), CSR holds 0x0000_000F → rd_en at +1; wr_en at +3 with wdata 0x0000_00FF; done at +4 with rd_we=1, rd_data=0x0000_000F.
- CSRRCI x1, 0x300, zimm=3, CSR=0xFFFF_FFFF → wdata 0xFFFF_FFFC, rd_data 0xFFFF_FFFF.
- CSRRW x0, 0x305, rs1 val 0x8000_0000 → no rd_en; wr_en at +1 with wdata 0x8000_0000; done at +2 with rd_we=0.
- CSRRS x7, 0xC00, rs1=x0, CSR=0x0000_1234 → no wr_en; done at +3 with rd_data 0x0000_1234 and illegal=0, macro on or off.
- CSRRW x7, 0xC80 with CSR_RO_CHECK_EN → no wr_en; illegal=1, rd_we=0. funct3=100 → done at +1 with illegal=1 and no strobes.
- Assert rst_n low during WRITE → all strobes 0 the same cycle; req_ready=1 after release; the next request completes normally.
